// File: rtl/i2c_ctrl.sv
// i2c_ctrl: register-mapped I2C master sequencer issuing START, STOP, byte WRITE and byte READ.
// Define I2C_INT_EN to store the IE bit and emit a one-cycle command-complete interrupt.
module i2c_ctrl #(
  parameter logic [15:0] RST_DIV = 16'd24
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_memAddr,
  input  logic [15:0] i_memDataIn,
  input  logic        i_memWrEn,
  output logic [15:0] o_memDataOut,
  input  logic        i_i2cSDAIn,
  output logic        o_i2cSCLDir,
  output logic        o_i2cSDADir,
  output logic        o_intI2C
);

  localparam int unsigned DivW    = 16;
  localparam int unsigned BitCntW = 3;
  localparam int unsigned ByteW   = 8;

  localparam logic [1:0] AddrCtrl = 2'b00;
  localparam logic [1:0] AddrData = 2'b01;
  localparam logic [1:0] AddrDiv  = 2'b10;

  localparam logic [1:0] CmdStart = 2'b00;
  localparam logic [1:0] CmdStop  = 2'b01;
  localparam logic [1:0] CmdWrite = 2'b10;
  localparam logic [1:0] CmdRead  = 2'b11;

  typedef enum logic [3:0] {
    IDLE, ST1, ST2, ST3, ST4,
    BIT_A, BIT_B, BIT_H,
    ACK_A, ACK_B, ACK_H,
    SP1, SP2, SP3
  } state_t;

  state_t               state;
  logic [DivW-1:0]      phaseCnt;
  logic [BitCntW-1:0]   bitCnt;
  logic [DivW-1:0]      div;
  logic [ByteW-1:0]     tx;
  logic [ByteW-1:0]     rx;
  logic                 nack;
  logic                 ackOut;
  logic [1:0]           cmd;
  logic                 ie;

  logic                 busy;
  logic                 phaseDone;
  logic                 ctrlWr;
  logic                 goAccept;
  logic [BitCntW-1:0]   bitIdx;
  logic                 unusedBits;

  assign busy      = (state != IDLE);
  assign phaseDone = (phaseCnt == div);
  assign ctrlWr    = i_memWrEn && (i_memAddr == AddrCtrl);
  assign goAccept  = ctrlWr && i_memDataIn[15] && !busy;
  assign bitIdx    = 3'd7 - bitCnt;
  assign unusedBits = ^i_memDataIn[14:3];

`ifndef I2C_INT_EN
  assign ie       = 1'b0;
  assign o_intI2C = 1'b0;
`endif

  // Register file, command launch and phase sequencer; Dir outputs move only on phase entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      phaseCnt    <= '0;
      bitCnt      <= '0;
      div         <= RST_DIV;
      tx          <= '0;
      rx          <= '0;
      nack        <= 1'b0;
      ackOut      <= 1'b0;
      cmd         <= CmdStart;
      o_i2cSCLDir <= 1'b0;
      o_i2cSDADir <= 1'b0;
`ifdef I2C_INT_EN
      ie          <= 1'b0;
      o_intI2C    <= 1'b0;
`endif
    end else begin
`ifdef I2C_INT_EN
      o_intI2C <= 1'b0;
      if (ctrlWr && !(busy && i_memDataIn[15])) ie <= i_memDataIn[3];
`endif
      if (i_memWrEn && !busy) begin
        case (i_memAddr)
          AddrCtrl: begin
            ackOut <= i_memDataIn[2];
            cmd    <= i_memDataIn[1:0];
          end
          AddrData: tx  <= i_memDataIn[ByteW-1:0];
          AddrDiv:  div <= i_memDataIn;
          default: ;
        endcase
      end

      if (goAccept) begin
        phaseCnt <= '0;
        bitCnt   <= '0;
        case (i_memDataIn[1:0])
          CmdStart: begin
            state       <= ST1;
            o_i2cSDADir <= 1'b0;
          end
          CmdStop: begin
            state       <= SP1;
            o_i2cSCLDir <= 1'b1;
            o_i2cSDADir <= 1'b1;
          end
          default: begin
            state       <= BIT_A;
            o_i2cSCLDir <= 1'b1;
          end
        endcase
      end else if (busy) begin
        if (!phaseDone) begin
          phaseCnt <= phaseCnt + 16'd1;
        end else begin
          phaseCnt <= '0;
          case (state)
            ST1: begin state <= ST2; o_i2cSCLDir <= 1'b0; end
            ST2: begin state <= ST3; o_i2cSDADir <= 1'b1; end
            ST3: begin state <= ST4; o_i2cSCLDir <= 1'b1; end
            SP1: begin state <= SP2; o_i2cSCLDir <= 1'b0; end
            SP2: begin state <= SP3; o_i2cSDADir <= 1'b0; end
            BIT_A: begin
              state       <= BIT_B;
              o_i2cSDADir <= (cmd == CmdWrite) ? ~tx[bitIdx] : 1'b0;
            end
            BIT_B: begin state <= BIT_H; o_i2cSCLDir <= 1'b0; end
            BIT_H: begin
              if (cmd == CmdRead) rx <= {rx[ByteW-2:0], i_i2cSDAIn};
              o_i2cSCLDir <= 1'b1;
              if (bitCnt == 3'd7) begin
                bitCnt <= '0;
                state  <= ACK_A;
              end else begin
                bitCnt <= bitCnt + 3'd1;
                state  <= BIT_A;
              end
            end
            ACK_A: begin
              state       <= ACK_B;
              o_i2cSDADir <= (cmd == CmdWrite) ? 1'b0 : ~ackOut;
            end
            ACK_B: begin state <= ACK_H; o_i2cSCLDir <= 1'b0; end
            ACK_H: begin
              if (cmd == CmdWrite) nack <= i_i2cSDAIn;
              state <= IDLE;
`ifdef I2C_INT_EN
              o_intI2C <= ie;
`endif
            end
            default: begin
              state <= IDLE;
`ifdef I2C_INT_EN
              o_intI2C <= ie;
`endif
            end
          endcase
        end
      end
    end
  end

  // Combinational register read mux.
  always_comb begin
    o_memDataOut = '0;
    case (i_memAddr)
      AddrCtrl: o_memDataOut = {busy, nack, 10'd0, ie, ackOut, cmd};
      AddrData: o_memDataOut = {8'h00, rx};
      AddrDiv:  o_memDataOut = div;
      default:  o_memDataOut = '0;
    endcase
  end

endmodule

// File: tb/tb_i2c_ctrl.sv
// tb_i2c_ctrl: phase-level bus model of i2c_ctrl compared against the DUT on every cycle,
// driven by directed scenarios followed by randomized commands.
module tb_i2c_ctrl;

`ifdef I2C_INT_EN
  localparam logic IntEn = 1'b1;
`else
  localparam logic IntEn = 1'b0;
`endif

  typedef struct packed {
    logic scl;
    logic sda;
    logic busy;
    logic intr;
    logic sdaIn;
  } exp_t;

  typedef struct packed {
    logic scl;
    logic sda;
    logic keyed;
    logic key;
  } ph_t;

  logic        clk;
  logic        rst;
  logic [1:0]  memAddr;
  logic [15:0] memDataIn;
  logic        memWrEn;
  logic [15:0] memDataOut;
  logic        sdaIn;
  logic        sclDir;
  logic        sdaDir;
  logic        intI2C;

  i2c_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_memAddr    (memAddr),
    .i_memDataIn  (memDataIn),
    .i_memWrEn    (memWrEn),
    .o_memDataOut (memDataOut),
    .i_i2cSDAIn   (sdaIn),
    .o_i2cSCLDir  (sclDir),
    .o_i2cSDADir  (sdaDir),
    .o_intI2C     (intI2C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        expQ[$];
  logic        mScl = 1'b0;
  logic        mSda = 1'b0;
  logic [15:0] mDiv;
  logic [7:0]  mTx, mRx;
  logic        mNack, mIe, mAck;
  logic [1:0]  mCmd;
  int          lastLen;
  logic [7:0]  lastBitB;
  int          busyCnt = 0;
  int          intCnt = 0;
  bit          checkEn = 1'b0;
  int          nAssert = 0;
  int          nFail = 0;

  function automatic void check(input string name, input logic [15:0] act, input logic [15:0] req);
    nAssert++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endfunction

  // Per-cycle comparison against the model timeline; also drives the SDA input level.
  always @(negedge clk) begin : cmpProc
    exp_t e;
    if (!checkEn) begin
      sdaIn = 1'b1;
    end else begin
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        mScl = e.scl;
        mSda = e.sda;
      end else begin
        e.scl = mScl;
        e.sda = mSda;
        e.busy = 1'b0;
        e.intr = 1'b0;
        e.sdaIn = 1'($urandom);
      end
      sdaIn = e.sdaIn;
      check("sclDir", 16'(sclDir), 16'(e.scl));
      check("sdaDir", 16'(sdaDir), 16'(e.sda));
      check("intI2C", 16'(intI2C), 16'(e.intr));
      if (intI2C === 1'b1) intCnt++;
      if (memAddr == 2'b00) begin
        check("busy", 16'(memDataOut[15]), 16'(e.busy));
        if (memDataOut[15] === 1'b1) busyCnt++;
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    memAddr = a; memDataIn = d; memWrEn = 1'b1;
    @(posedge clk); #1;
    memWrEn = 1'b0; memAddr = 2'b00;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [15:0] req);
    @(posedge clk); #1;
    memAddr = a;
    #1;
    check(name, memDataOut, req);
    memAddr = 2'b00;
  endtask

  // Expand the command into bus phases from the protocol rules, then into cycles.
  task automatic buildCmd(input logic [7:0] rxByte, input logic ackLevel);
    ph_t  ph[$];
    exp_t e;
    logic prev, b;
    lastLen = 0;
    lastBitB = 8'h00;
    case (mCmd)
      2'b00: begin
        ph.push_back('{scl: mScl, sda: 1'b0, keyed: 1'b0, key: 1'b0});
        ph.push_back('{scl: 1'b0, sda: 1'b0, keyed: 1'b0, key: 1'b0});
        ph.push_back('{scl: 1'b0, sda: 1'b1, keyed: 1'b0, key: 1'b0});
        ph.push_back('{scl: 1'b1, sda: 1'b1, keyed: 1'b0, key: 1'b0});
      end
      2'b01: begin
        ph.push_back('{scl: 1'b1, sda: 1'b1, keyed: 1'b0, key: 1'b0});
        ph.push_back('{scl: 1'b0, sda: 1'b1, keyed: 1'b0, key: 1'b0});
        ph.push_back('{scl: 1'b0, sda: 1'b0, keyed: 1'b0, key: 1'b0});
      end
      default: begin
        prev = mSda;
        for (int i = 7; i >= 0; i--) begin
          b = (mCmd == 2'b10) ? ~mTx[i] : 1'b0;
          lastBitB[i] = b;
          ph.push_back('{scl: 1'b1, sda: prev, keyed: 1'b0, key: 1'b0});
          ph.push_back('{scl: 1'b1, sda: b, keyed: 1'b0, key: 1'b0});
          ph.push_back('{scl: 1'b0, sda: b, keyed: (mCmd == 2'b11), key: rxByte[i]});
          prev = b;
        end
        b = (mCmd == 2'b10) ? 1'b0 : ~mAck;
        ph.push_back('{scl: 1'b1, sda: prev, keyed: 1'b0, key: 1'b0});
        ph.push_back('{scl: 1'b1, sda: b, keyed: 1'b0, key: 1'b0});
        ph.push_back('{scl: 1'b0, sda: b, keyed: (mCmd == 2'b10), key: ackLevel});
        if (mCmd == 2'b10) mNack = ackLevel;
        else mRx = rxByte;
      end
    endcase
    foreach (ph[p]) begin
      for (int c = 0; c <= int'(mDiv); c++) begin
        e.scl = ph[p].scl;
        e.sda = ph[p].sda;
        e.busy = 1'b1;
        e.intr = 1'b0;
        e.sdaIn = (ph[p].keyed && c == int'(mDiv)) ? ph[p].key : 1'($urandom);
        expQ.push_back(e);
        lastLen++;
      end
    end
    e.scl = ph[ph.size()-1].scl;
    e.sda = ph[ph.size()-1].sda;
    e.busy = 1'b0;
    e.intr = mIe;
    e.sdaIn = 1'($urandom);
    expQ.push_back(e);
  endtask

  task automatic startCmd(input logic [1:0] cmd, input logic ack, input logic ie, input logic load,
                          input logic [15:0] div, input logic [7:0] tx,
                          input logic [7:0] rxByte, input logic ackLevel);
    if (load) begin
      wr(2'b10, div);
      mDiv = div;
      wr(2'b01, {8'h00, tx});
      mTx = tx;
    end
    wr(2'b00, {1'b1, 11'd0, ie, ack, cmd});
    mIe = ie & IntEn;
    mAck = ack;
    mCmd = cmd;
    buildCmd(rxByte, ackLevel);
  endtask

  task automatic finishCmd();
    int guard = 0;
    while (expQ.size() > 0 && guard < 4000) begin
      @(posedge clk);
      guard++;
    end
    check("cmdDone", 16'(expQ.size()), 16'd0);
    rd("ctrlRd", 2'b00, {1'b0, mNack, 10'd0, mIe, mAck, mCmd});
    rd("dataRd", 2'b01, {8'h00, mRx});
    rd("divRd", 2'b10, mDiv);
  endtask

  task automatic runCmd(input logic [1:0] cmd, input logic ack, input logic ie, input logic load,
                        input logic [15:0] div, input logic [7:0] tx, input logic [7:0] rxByte,
                        input logic ackLevel, input logic mid);
    startCmd(cmd, ack, ie, load, div, tx, rxByte, ackLevel);
    if (mid) begin
      wr(2'b01, {8'h00, ~mTx});
      wr(2'b10, 16'($urandom));
      wr(2'b00, {1'b1, 11'd0, ie, ~ack, ~cmd});
    end
    finishCmd();
  endtask

  initial begin
    int b0, i0;
    rst = 1'b1; memAddr = 2'b00; memDataIn = 16'h0000; memWrEn = 1'b0;
    mDiv = 16'd24; mTx = 8'h00; mRx = 8'h00; mNack = 1'b0; mIe = 1'b0; mAck = 1'b0; mCmd = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkEn = 1'b1;

    rd("rstDiv", 2'b10, 16'd24);
    rd("rstCtrl", 2'b00, 16'h0000);
    check("rstScl", 16'(sclDir), 16'd0);
    check("rstSda", 16'(sdaDir), 16'd0);

    b0 = busyCnt;
    runCmd(2'b00, 1'b0, 1'b0, 1'b1, 16'd1, 8'h00, 8'h00, 1'b0, 1'b0);
    check("startLen", 16'(lastLen), 16'd8);
    check("startBusy", 16'(busyCnt - b0), 16'd8);
    check("startScl", 16'(sclDir), 16'd1);
    check("startSda", 16'(sdaDir), 16'd1);

    b0 = busyCnt;
    runCmd(2'b10, 1'b0, 1'b0, 1'b1, 16'd1, 8'hA5, 8'h00, 1'b0, 1'b0);
    check("wrBitB", 16'(lastBitB), 16'h005A);
    check("wrBusy", 16'(busyCnt - b0), 16'd54);
    rd("wrAckCtrl", 2'b00, 16'h0002);

    runCmd(2'b10, 1'b0, 1'b0, 1'b1, 16'd1, 8'hA5, 8'h00, 1'b1, 1'b1);
    rd("wrNackCtrl", 2'b00, 16'h4002);
    runCmd(2'b10, 1'b0, 1'b0, 1'b0, 16'd1, 8'hA5, 8'h00, 1'b0, 1'b0);
    check("txKeptBitB", 16'(lastBitB), 16'h005A);

    i0 = intCnt;
    runCmd(2'b11, 1'b1, 1'b1, 1'b1, 16'd1, 8'h00, 8'h3C, 1'b0, 1'b0);
    rd("rdData", 2'b01, 16'h003C);
    rd("rdCtrl", 2'b00, IntEn ? 16'h000F : 16'h0007);
    check("rdIntCount", 16'(intCnt - i0), IntEn ? 16'd1 : 16'd0);

    for (int n = 0; n < 30; n++) begin
      logic [1:0] c;
      c = 2'($urandom_range(0, 3));
      runCmd(c, 1'($urandom), 1'($urandom), (n == 0) || ($urandom_range(0, 3) != 0),
             16'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom),
             c[1] && 1'($urandom));
    end

    // Abort a WRITE once it reaches BIT_B.
    i0 = intCnt;
    startCmd(2'b10, 1'b0, 1'b1, 1'b1, 16'd1, 8'hA5, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    expQ.delete();
    expQ.push_back('{scl: 1'b0, sda: 1'b0, busy: 1'b0, intr: 1'b0, sdaIn: 1'b1});
    mDiv = 16'd24; mTx = 8'h00; mRx = 8'h00; mNack = 1'b0; mIe = 1'b0; mAck = 1'b0; mCmd = 2'b00;
    check("abortScl", 16'(sclDir), 16'd0);
    check("abortSda", 16'(sdaDir), 16'd0);
    rd("abortCtrl", 2'b00, 16'h0000);
    rd("abortDiv", 2'b10, 16'd24);
    repeat (5) @(posedge clk);
    check("abortInt", 16'(intCnt - i0), 16'd0);

    runCmd(2'b01, 1'b0, 1'b0, 1'b1, 16'd0, 8'h00, 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/i2c_ctrl.md
I2C_CTRL -- requirements
Module: i2c_ctrl

Interface
REQ-001 The clock is i_clk; the module uses only this clock; reset is synchronous and active-high on i_rst.
REQ-002 Parameter RST_DIV, default 16'd24, sets the reset value of the DIV register.
REQ-003 i_clk  input  1  system clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  synchronous active-high reset.
REQ-005 i_memAddr  input  2  register select: 00 CTRL, 01 DATA, 10 DIV, 11 reserved.
REQ-006 i_memDataIn  input  16  write data.
REQ-007 i_memWrEn  input  1  write strobe; register updates on the same clock edge.
REQ-008 o_memDataOut  output  16  combinational read data for i_memAddr.
REQ-009 i_i2cSDAIn  input  1  synchronized SDA level from the GPIO block; reads 1 when I2C alt function is disabled.
REQ-010 o_i2cSCLDir  output  1  1 = pull SCL low, 0 = release.
REQ-011 o_i2cSDADir  output  1  1 = pull SDA low, 0 = release.
REQ-012 o_intI2C  output  1  one-cycle command-complete interrupt pulse.

Function
REQ-013 CTRL write fields: [15] GO, [3] IE, [2] ACKOUT, [1:0] CMD (00 START, 01 STOP, 10 WRITE, 11 READ).
REQ-014 CTRL read fields: [15] BUSY, [14] NACKRX, [3] IE, [2:0] last written {ACKOUT,CMD}, other bits 0.
REQ-015 DATA write loads the TX byte from [7:0]; DATA read returns {8'h00, RX byte}.
REQ-016 DIV read/write is 16-bit; each phase lasts DIV+1 clocks; DIV=0 gives 1-clock phases.
REQ-017 Address 11 reads 16'h0000; writes to it are ignored.
REQ-018 A CTRL write with GO=1 while BUSY=0 sets BUSY on the next edge and starts CMD with the phase counter at 0.
REQ-019 A CTRL write with GO=1 while BUSY=1 is ignored entirely; DATA and DIV writes while BUSY=1 are ignored; IE writes are always accepted.
REQ-020 The FSM has states IDLE, ST1-ST4, BIT_A, BIT_B, BIT_H, ACK_A, ACK_B, ACK_H, SP1-SP3; each non-IDLE state lasts exactly one phase.
REQ-021 START: ST1 releases SDA (SCL unchanged); ST2 releases SCL; ST3 drives SDA low; ST4 drives SCL low; then IDLE. From bus-idle this is a plain start; from SCL-low it is a repeated start.
REQ-022 STOP: SP1 holds SCL low and drives SDA low; SP2 releases SCL; SP3 releases SDA; then IDLE.
REQ-023 Each data bit, MSB first: BIT_A drives SCL low with SDA held; BIT_B keeps SCL low and sets SDA; BIT_H releases SCL.
REQ-024 WRITE: in BIT_B, o_i2cSDADir = ~TX bit. In ACK_B, SDA is released. On the last cycle of ACK_H, NACKRX is set to i_i2cSDAIn.
REQ-025 READ: SDA is released for all data bits; i_i2cSDAIn is shifted into RX on the last cycle of each BIT_H. In ACK_B, o_i2cSDADir = ~ACKOUT. NACKRX is unchanged.
REQ-026 Both WRITE and READ take 8x3 data phases plus 3 ack phases (27 phases) and leave SCL released at the end of ACK_H. The next command starts with BIT_A or ST1, which pulls SCL low.
REQ-027 BUSY clears on the edge following the final phase's last cycle; the FSM returns to IDLE on that same edge.
REQ-028 Only the bit counter (3 bits) and the phase counter (16 bits) are counted; both wrap-free, since the FSM exits before overflow.
REQ-029 The two Dir outputs are registered; they change only on phase boundaries or reset.

Reset
REQ-030 On i_rst: FSM IDLE, BUSY 0, NACKRX 0, IE 0, CMD/ACKOUT 0, TX 0, RX 0, DIV = RST_DIV, counters 0, o_i2cSCLDir 0, o_i2cSDADir 0, o_intI2C 0.
REQ-031 A reset asserted mid-command aborts the command and releases both lines on that edge; no interrupt is emitted.

Configuration
REQ-032 With I2C_INT_EN defined, o_intI2C pulses high for exactly one cycle, coincident with BUSY falling, when IE=1.
REQ-033 Without I2C_INT_EN, o_intI2C is constant 0, IE is not stored, and CTRL[3] reads 0.

Verification
REQ-034 Reset, then read DIV -> 16'd24; read CTRL -> 16'h0000; both Dir outputs 0.
REQ-035 DIV=1, then CTRL=16'h8000 (START) -> BUSY=1 for 8 cycles; SDA low 2 cycles before SCL low; BUSY then 0, with SCL=1 and SDA=1 on the Dir outputs.
REQ-036 DIV=1, DATA=8'hA5, CTRL=16'h8002, SDA input tied 0 during ACK_H -> the SDADir sequence is 0,1,0,1,1,0,1,0 in BIT_B; BUSY lasts 54 cycles; NACKRX=0.
REQ-037 The same WRITE with the SDA input held 1 -> NACKRX=1; a GO written mid-command is ignored and DATA keeps 8'hA5.
REQ-038 READ (CTRL=16'h8007) with SDA input driving 8'h3C -> DATA reads 16'h003C; SDADir=0 through ACK_B (NACK); with IE=1 and I2C_INT_EN, o_intI2C pulses one cycle.
REQ-039 Assert i_rst during BIT_B of a WRITE -> both Dir outputs 0 next edge; BUSY 0; no interrupt.
